// File: rtl/alu_pkg.sv
// Shared encodings and payload types for the execute-stage ALU.
package alu_pkg;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SLT  = 3'd5,
        OP_MUL  = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_MUL_RUN = 1'b1
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             overflow;
        logic             zero;
    } res_t;

endpackage

// File: rtl/mul_seq_64.sv
// Iterative shift-add multiplier: one partial-product step per cycle, fixed 64 steps.
module mul_seq_64
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod
);

    logic [WIDTH-1:0] mcand_d, mcand_q;
    logic [WIDTH-1:0] mplier_d, mplier_q;
    logic [WIDTH-1:0] acc_d, acc_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             busy_d, busy_q;
    logic [WIDTH-1:0] acc_step;

    // prod is the accumulator after the current step, so the final step's sum is usable on its own edge
    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign prod = acc_step;

endmodule

// File: rtl/alu_ex_stage.sv
// Execute-stage ALU: single-cycle add/sub/logic/slt, iterative MUL, registered result with flags.
module alu_ex_stage #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    import alu_pkg::*;

    state_e           state_d, state_q;
    res_t             res_d, res_q;
    res_t             alu_res;
    logic             out_valid_d, out_valid_q;
    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             accept;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;

    // Single-cycle datapath; ADD and SUB share one adder with b inverted and carry-in for SUB
    always_comb begin
        sub     = (op == OP_SUB);
        b_eff   = b ^ {WIDTH{sub}};
        sum     = {1'b0, a} + {1'b0, b_eff} + (WIDTH + 1)'(sub);
        alu_res = '0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res.result   = sum[WIDTH-1:0];
                alu_res.carry    = sum[WIDTH];
                alu_res.overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res.result = a & b;
            OP_OR:   alu_res.result = a | b;
            OP_XOR:  alu_res.result = a ^ b;
            OP_SLT:  alu_res.result = WIDTH'($signed(a) < $signed(b));
            default: alu_res.result = '0;
        endcase
        alu_res.zero = (alu_res.result == '0);
    end

    // Handshake, FSM and output-register load
    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        mul_start   = 1'b0;
        in_ready    = !rst && (state_q == S_IDLE) && !mul_busy && (!out_valid_q || out_ready);
        accept      = in_valid && in_ready;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = S_MUL_RUN;
                    end else begin
                        res_d       = alu_res;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL_RUN: begin
                if (mul_done) begin
                    res_d.result   = mul_prod;
                    res_d.carry    = 1'b0;
                    res_d.overflow = 1'b0;
                    res_d.zero     = (mul_prod == '0);
                    out_valid_d    = 1'b1;
                    state_d        = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

    mul_seq_64 u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    assign out_valid = out_valid_q;
    assign result    = res_q.result;
    assign carry     = res_q.carry;
    assign overflow  = res_q.overflow;
    assign zero      = res_q.zero;

endmodule
